multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Parametrised multicycle control unit driving the Datapath control pins (PCWriteCond..RegDst).
//  Sequences fetch/decode/execute/mem/writeback per instruction instead of bench-driven stimulus.
//  Adds a memory ready handshake (wait states), funct-decoded ALU ops and an illegal-opcode flag.
//  Sits between instruction register fields (opcode/funct) and Datapath.
// PARAMETERS
//  OPCODE_W  6        opcode/funct field width
//  ALUOP_W   4        ALUOp output width
//  OP_RTYPE  6'h00    R-type opcode
//  OP_LW     6'h23    load word opcode
//  OP_SW     6'h2B    store word opcode
//  OP_BEQ    6'h04    branch-equal opcode
//  OP_J      6'h02    jump opcode
//  OP_ADDI   6'h08    add-immediate opcode (used only with ADDI_EN)
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          asynchronous, active-low reset
//  opcode       in   OPCODE_W   IR[31:26], valid from DECODE onward
//  funct        in   OPCODE_W   IR[5:0]
//  mem_ready    in   1          memory completes current access this cycle
//  PCWriteCond  out  1          conditional PC write (branch)
//  PCWrite      out  1          unconditional PC write
//  MemRead      out  1          memory read request
//  MemWrite     out  1          memory write request
//  MemtoReg     out  1          write-back source = MDR
//  IRWrite      out  1          latch instruction register
//  PCSource     out  2          00 ALU, 01 ALUOut, 10 jump target
//  ALUOp        out  ALUOP_W    0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
//  ALUSrcB      out  2          00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  ALUSrcA      out  1          0 PC, 1 A
//  RegWrite     out  1          register file write enable
//  RegDst       out  1          1 rd, 0 rt
//  state        out  4          current state code (debug)
//  illegal_op   out  1          one-cycle pulse on unknown opcode in DECODE
// BEHAVIOUR
//  Moore decode of state register; exceptions noted. States (code):
//   RST(15) -> FETCH(0) unconditionally, one cycle after reset release.
//   FETCH(0): MemRead, IRWrite, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00; PCWrite=mem_ready.
//     IRWrite/PCWrite gated by mem_ready (Mealy); stay while mem_ready=0; ->DECODE when 1.
//   DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=add. Next by opcode: LW/SW->MEM_ADDR, RTYPE->EXEC,
//     BEQ->BRANCH, J->JUMP, ADDI->I_EXEC (ADDI_EN), else illegal_op=1 and ->FETCH.
//   MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, add; ->MEM_RD if LW, ->MEM_WR if SW.
//   MEM_RD(3): MemRead; hold until mem_ready; ->MEM_WB.
//   MEM_WB(4): RegWrite, MemtoReg=1, RegDst=0; ->FETCH.
//   MEM_WR(5): MemWrite; hold until mem_ready; ->FETCH.
//   EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp from funct (20 add,22 sub,24 and,25 or,2A slt; other->add
//     and illegal_op pulse); ->R_WB.
//   R_WB(7): RegWrite, RegDst=1, MemtoReg=0; ALUOp held from EXEC; ->FETCH.
//   BRANCH(8): ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond, PCSource=01; ->FETCH.
//   JUMP(9): PCWrite, PCSource=10; ->FETCH.
//  Any signal not listed for a state is 0. In RST every output is 0, state=15.
//  reset low asynchronously forces RST mid-instruction; pending access is abandoned.
//  Unused codes (10..14 without ADDI_EN) -> RST next cycle.
//  mem_ready ignored outside FETCH/MEM_RD/MEM_WR. Min CPI: R=4, LW=5, SW=4, BEQ=3, J=3.
// CONFIGURATION
//  ADDI_EN defined: I_EXEC(10) ALUSrcA=1, ALUSrcB=10, add ->I_WB(11) RegWrite, RegDst=0 ->FETCH.
//  ADDI_EN undefined: OP_ADDI is illegal (illegal_op pulse, ->FETCH); codes 10/11 unused.
// STRUCTURE
//  Shared package: state codes, ALUOp encodings, PCSource/ALUSrcB encodings, funct constants.
//  One sub-module: alu_funct_decode (funct -> ALUOp + illegal flag, combinational).
// TESTING
//  reset low 100ns, release -> RST one cycle then FETCH; MemRead=1, IRWrite=1 while mem_ready=1.
//  R-type opcode 00 funct 22, mem_ready=1 -> states 0,1,6,7,0; ALUOp=0110 in 6/7; RegWrite only in 7.
//  LW opcode 23, mem_ready low 3 cycles in MEM_RD -> state 3 held 4 cycles, then 4 with MemtoReg=1.
//  BEQ opcode 04 -> states 0,1,8,0; PCWriteCond=1, PCSource=01, ALUOp=0110 in state 8 only.
//  opcode 3F -> illegal_op high exactly one cycle in DECODE, next state FETCH, no RegWrite/MemWrite.
//  reset pulsed low during MEM_WR -> outputs 0 immediately; ADDI_EN build: opcode 08 -> 0,1,10,11,0.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm_pkg
//   Shared definitions for the multicycle control unit: state codes, ALUOp,
//   PCSource and ALUSrcB encodings, funct constants, the per-state control
//   word and the Moore control-word lookup used by the top.
// -----------------------------------------------------------------------------
package multicycle_control_fsm_pkg;

  // State codes are visible on the debug port, so the values are fixed.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_RST      = 4'd15
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // pcwrite_gated / irwrite_gated are ANDed with mem_ready at the output so
  // FETCH only commits PC and IR in the cycle the memory delivers.
  typedef struct packed {
    logic       pcwritecond;
    logic       pcwrite;
    logic       pcwrite_gated;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite_gated;
    logic [1:0] pcsource;
    logic [3:0] aluop;
    logic [1:0] alusrcb;
    logic       alusrca;
    logic       regwrite;
    logic       regdst;
  } ctrl_t;

  function automatic ctrl_t ctrl_for_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memread       = 1'b1;
        c.irwrite_gated = 1'b1;
        c.pcwrite_gated = 1'b1;
        c.alusrca       = 1'b0;
        c.alusrcb       = SRCB_FOUR;
        c.aluop         = ALU_ADD;
        c.pcsource      = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_IMM_SH2;
        c.aluop   = ALU_ADD;
      end
      S_MEM_ADDR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALU_ADD;
      end
      S_MEM_RD: c.memread = 1'b1;
      S_MEM_WB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEM_WR: c.memwrite = 1'b1;
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_B;
      end
      S_R_WB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = SRCB_B;
        c.aluop       = ALU_SUB;
        c.pcwritecond = 1'b1;
        c.pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = PCSRC_JUMP;
      end
      S_I_EXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALU_ADD;
      end
      S_I_WB: c.regwrite = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_funct_decode.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm_alu_funct_decode
//   Combinational R-type funct decode into an ALUOp code. Unknown funct
//   values fall back to add and raise o_illegal.
// Ports
//   i_funct    in  FUNCT_W  funct field IR[5:0]
//   o_aluop    out 4        ALU operation code
//   o_illegal  out 1        funct not recognised
// -----------------------------------------------------------------------------
module multicycle_control_fsm_alu_funct_decode
  import multicycle_control_fsm_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [FUNCT_W-1:0] i_funct,
  output logic [3:0]         o_aluop,
  output logic               o_illegal
);

  always_comb begin
    o_aluop   = ALU_ADD;
    o_illegal = 1'b0;
    if (i_funct == FUNCT_W'(FUNCT_ADD)) begin
      o_aluop = ALU_ADD;
    end else if (i_funct == FUNCT_W'(FUNCT_SUB)) begin
      o_aluop = ALU_SUB;
    end else if (i_funct == FUNCT_W'(FUNCT_AND)) begin
      o_aluop = ALU_AND;
    end else if (i_funct == FUNCT_W'(FUNCT_OR)) begin
      o_aluop = ALU_OR;
    end else if (i_funct == FUNCT_W'(FUNCT_SLT)) begin
      o_aluop = ALU_SLT;
    end else begin
      o_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//   Multicycle control unit: sequences fetch / decode / execute / memory /
//   write-back for each instruction and drives the datapath control pins.
//   Memory accesses wait on mem_ready; R-type ALU ops come from funct.
//   Optional feature macro: ADDI_EN (adds I_EXEC/I_WB for add-immediate).
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   opcode       in   IR[31:26], valid from DECODE onward
//   funct        in   IR[5:0]
//   mem_ready    in   memory completes current access this cycle
//   PCWriteCond  out  conditional PC write
//   PCWrite      out  unconditional PC write
//   MemRead      out  memory read request
//   MemWrite     out  memory write request
//   MemtoReg     out  write-back source = MDR
//   IRWrite      out  latch instruction register
//   PCSource     out  00 ALU, 01 ALUOut, 10 jump target
//   ALUOp        out  ALU operation
//   ALUSrcB      out  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   ALUSrcA      out  0 PC, 1 A
//   RegWrite     out  register file write enable
//   RegDst       out  1 rd, 0 rt
//   state        out  current state code
//   illegal_op   out  pulse on unknown opcode (DECODE) or funct (EXEC)
//
// state    | meaning
// RST  15  | held in reset / recovery from an unused code
// FETCH 0  | read instruction, PC+4; waits for mem_ready
// DECODE 1 | branch target precompute, dispatch on opcode
// MEM_ADDR 2 | A + sign-ext imm
// MEM_RD 3 | load read, waits for mem_ready
// MEM_WB 4 | MDR -> rt
// MEM_WR 5 | store write, waits for mem_ready
// EXEC 6   | R-type ALU operation
// R_WB 7   | ALUOut -> rd
// BRANCH 8 | compare A-B, conditional PC write
// JUMP 9   | PC <- jump target
// I_EXEC 10| add-immediate ALU (ADDI_EN)
// I_WB 11  | ALUOut -> rt (ADDI_EN)
// -----------------------------------------------------------------------------
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int                  OPCODE_W = 6,
  parameter int                  ALUOP_W  = 4,
  parameter logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'h00),
  parameter logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'h23),
  parameter logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'h2B),
  parameter logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'h04),
  parameter logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'h02),
  parameter logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'h08)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [OPCODE_W-1:0] funct,
  input  logic                mem_ready,
  output logic                PCWriteCond,
  output logic                PCWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic [1:0]          PCSource,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          ALUSrcB,
  output logic                ALUSrcA,
  output logic                RegWrite,
  output logic                RegDst,
  output logic [3:0]          state,
  output logic                illegal_op
);

`ifdef ADDI_EN
  localparam bit ADDI_ON = 1'b1;
`else
  localparam bit ADDI_ON = 1'b0;
`endif

  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  ctrl_t      w_next_ctrl;
  logic       r_illegal_funct;
  logic [3:0] w_funct_aluop;
  logic       w_funct_illegal;
  logic       w_is_rtype;
  logic       w_is_lw;
  logic       w_is_sw;
  logic       w_is_beq;
  logic       w_is_j;
  logic       w_is_addi;
  logic       w_op_legal;

  multicycle_control_fsm_alu_funct_decode #(
    .FUNCT_W (OPCODE_W)
  ) u_funct_dec (
    .i_funct   (funct),
    .o_aluop   (w_funct_aluop),
    .o_illegal (w_funct_illegal)
  );

  assign w_is_rtype = (opcode == OP_RTYPE);
  assign w_is_lw    = (opcode == OP_LW);
  assign w_is_sw    = (opcode == OP_SW);
  assign w_is_beq   = (opcode == OP_BEQ);
  assign w_is_j     = (opcode == OP_J);
  assign w_is_addi  = (opcode == OP_ADDI);
  assign w_op_legal = w_is_rtype | w_is_lw | w_is_sw | w_is_beq | w_is_j |
                      (ADDI_ON & w_is_addi);

  always_comb begin
    w_next = S_RST;
    case (r_state)
      S_RST:    w_next = S_FETCH;
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_is_lw || w_is_sw)         w_next = S_MEM_ADDR;
        else if (w_is_rtype)            w_next = S_EXEC;
        else if (w_is_beq)              w_next = S_BRANCH;
        else if (w_is_j)                w_next = S_JUMP;
        else if (ADDI_ON && w_is_addi)  w_next = S_I_EXEC;
        else                            w_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        if (w_is_lw)      w_next = S_MEM_RD;
        else if (w_is_sw) w_next = S_MEM_WR;
        else              w_next = S_FETCH;
      end
      S_MEM_RD: w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB: w_next = S_FETCH;
      S_MEM_WR: w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC:   w_next = S_R_WB;
      S_R_WB:   w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_I_EXEC: w_next = ADDI_ON ? S_I_WB : S_RST;
      S_I_WB:   w_next = ADDI_ON ? S_FETCH : S_RST;
      default:  w_next = S_RST;
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  // R_WB keeps the funct-derived ALUOp that EXEC used.
  always_comb begin
    w_next_ctrl = ctrl_for_state(w_next);
    if (w_next == S_EXEC) begin
      w_next_ctrl.aluop = w_funct_aluop;
    end else if (w_next == S_R_WB) begin
      w_next_ctrl.aluop = r_ctrl.aluop;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_RST;
      r_ctrl          <= '0;
      r_illegal_funct <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_ctrl          <= w_next_ctrl;
      r_illegal_funct <= (w_next == S_EXEC) && w_funct_illegal;
    end
  end

  assign PCWriteCond = r_ctrl.pcwritecond;
  assign PCWrite     = r_ctrl.pcwrite | (r_ctrl.pcwrite_gated & mem_ready);
  assign MemRead     = r_ctrl.memread;
  assign MemWrite    = r_ctrl.memwrite;
  assign MemtoReg    = r_ctrl.memtoreg;
  assign IRWrite     = r_ctrl.irwrite_gated & mem_ready;
  assign PCSource    = r_ctrl.pcsource;
  assign ALUOp       = ALUOP_W'(r_ctrl.aluop);
  assign ALUSrcB     = r_ctrl.alusrcb;
  assign ALUSrcA     = r_ctrl.alusrca;
  assign RegWrite    = r_ctrl.regwrite;
  assign RegDst      = r_ctrl.regdst;
  assign state       = r_state;

  // Opcode is only meaningful once the IR is loaded, so its check is live
  // during DECODE; the funct check was captured on entry to EXEC.
  assign illegal_op  = r_illegal_funct | ((r_state == S_DECODE) && !w_op_legal);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       PCWriteCond, PCWrite, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource;
  logic [3:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst;
  logic [3:0] state;
  logic       illegal_op;

  int checks = 0;
  int failures = 0;

  multicycle_control_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .mem_ready   (mem_ready),
    .PCWriteCond (PCWriteCond),
    .PCWrite     (PCWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .ALUSrcB     (ALUSrcB),
    .ALUSrcA     (ALUSrcA),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .state       (state),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  logic [21:0] dut_vec;
  assign dut_vec = {state, illegal_op, PCWriteCond, PCWrite, MemRead, MemWrite,
                    MemtoReg, IRWrite, PCSource, ALUOp, ALUSrcB, ALUSrcA,
                    RegWrite, RegDst};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_legal(input logic [5:0] op);
    bit ok;
    ok = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h02);
`ifdef ADDI_EN
    ok = ok || (op == 6'h08);
`endif
    return ok;
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'b0010;
      6'h22: return 4'b0110;
      6'h24: return 4'b0000;
      6'h25: return 4'b0001;
      6'h2A: return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic bit funct_known(input logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
  endfunction

  // Expected pin values for a state code, following the per-state output list.
  function automatic logic [21:0] exp_vec(input int st, input bit mr, input logic [5:0] op,
                                          input logic [5:0] fn);
    logic [3:0] sc, alu;
    logic [1:0] pcs, asb;
    bit ill, pwc, pw, mrd, mwr, m2r, irw, asa, rw, rd;
    sc = 4'(st); alu = 4'b0; pcs = 2'b0; asb = 2'b0;
    ill = 0; pwc = 0; pw = 0; mrd = 0; mwr = 0; m2r = 0; irw = 0; asa = 0; rw = 0; rd = 0;
    case (st)
      0:  begin mrd = 1; irw = mr; pw = mr; asb = 2'b01; alu = 4'b0010; end
      1:  begin asb = 2'b11; alu = 4'b0010; ill = !op_legal(op); end
      2:  begin asa = 1; asb = 2'b10; alu = 4'b0010; end
      3:  mrd = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  mwr = 1;
      6:  begin asa = 1; alu = funct_alu(fn); ill = !funct_known(fn); end
      7:  begin rw = 1; rd = 1; alu = funct_alu(fn); end
      8:  begin asa = 1; alu = 4'b0110; pwc = 1; pcs = 2'b01; end
      9:  begin pw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; alu = 4'b0010; end
      11: rw = 1;
      default: ;
    endcase
    return {sc, ill, pwc, pw, mrd, mwr, m2r, irw, pcs, alu, asb, asa, rw, rd};
  endfunction

  function automatic int exp_cpi(input logic [5:0] op, input int mw);
    if (op == 6'h00) return 4;
    if (op == 6'h23) return 5 + mw;
    if (op == 6'h2B) return 4 + mw;
    if (op == 6'h04 || op == 6'h02) return 3;
`ifdef ADDI_EN
    if (op == 6'h08) return 4;
`endif
    return 2;
  endfunction

  typedef struct {
    int st;
    bit mr;
  } cyc_t;

  // Builds the expected cycle list for one instruction, drives mem_ready from
  // it and checks every cycle. Entered and left just after a rising edge.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, output int cpi, output int ill, output int last);
    cyc_t q[$];
    int   ms;
    for (int i = 0; i < fw; i++) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, 1'($urandom_range(0, 1))});
    if (op == 6'h00) begin
      q.push_back('{6, 1'($urandom_range(0, 1))});
      q.push_back('{7, 1'($urandom_range(0, 1))});
    end else if (op == 6'h23 || op == 6'h2B) begin
      ms = (op == 6'h23) ? 3 : 5;
      q.push_back('{2, 1'($urandom_range(0, 1))});
      for (int i = 0; i < mw; i++) q.push_back('{ms, 1'b0});
      q.push_back('{ms, 1'b1});
      if (op == 6'h23) q.push_back('{4, 1'($urandom_range(0, 1))});
    end else if (op == 6'h04) begin
      q.push_back('{8, 1'($urandom_range(0, 1))});
    end else if (op == 6'h02) begin
      q.push_back('{9, 1'($urandom_range(0, 1))});
`ifdef ADDI_EN
    end else if (op == 6'h08) begin
      q.push_back('{10, 1'($urandom_range(0, 1))});
      q.push_back('{11, 1'($urandom_range(0, 1))});
`endif
    end
    cpi = 1; ill = 0; last = 0;
    foreach (q[i]) begin
      mem_ready = q[i].mr;
      opcode    = op;
      funct     = fn;
      @(negedge clk);
      check("cycle", 32'(dut_vec), 32'(exp_vec(q[i].st, q[i].mr, op, fn)));
      if (state != 4'd0) cpi++;
      if (illegal_op) ill++;
      last = int'(state);
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int fw;
    int mw;
    int cpi;
    int ill;
    int last;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cpi, ill, last;
    logic [5:0] ops[8];
    logic [5:0] fns[6];
    logic [5:0] op, fn;
    int mw;

    tbl[0]  = '{6'h00, 6'h22, 0, 0, 4, 0, 7};
    tbl[1]  = '{6'h00, 6'h20, 2, 0, 4, 0, 7};
    tbl[2]  = '{6'h00, 6'h3F, 0, 0, 4, 1, 7};
    tbl[3]  = '{6'h00, 6'h2A, 1, 0, 4, 0, 7};
    tbl[4]  = '{6'h23, 6'h00, 0, 3, 8, 0, 4};
    tbl[5]  = '{6'h23, 6'h11, 1, 0, 5, 0, 4};
    tbl[6]  = '{6'h2B, 6'h00, 0, 0, 4, 0, 5};
    tbl[7]  = '{6'h2B, 6'h00, 0, 2, 6, 0, 5};
    tbl[8]  = '{6'h04, 6'h00, 0, 0, 3, 0, 8};
    tbl[9]  = '{6'h02, 6'h00, 0, 0, 3, 0, 9};
    tbl[10] = '{6'h3F, 6'h20, 0, 0, 2, 1, 1};
`ifdef ADDI_EN
    tbl[11] = '{6'h08, 6'h00, 0, 0, 4, 0, 11};
`else
    tbl[11] = '{6'h08, 6'h00, 0, 0, 2, 1, 1};
`endif
    tbl[12] = '{6'h00, 6'h25, 0, 0, 4, 0, 7};

    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h15};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h07};

    reset = 1'b0; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00;
    #50;
    check("reset_hold", 32'(dut_vec), 32'(exp_vec(15, 1'b0, 6'h00, 6'h00)));
    #50;
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("rst_cycle", 32'(dut_vec), 32'(exp_vec(15, 1'b1, 6'h00, 6'h00)));
    @(posedge clk);
    #1;
    check("fetch_after_reset", 32'(state), 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].fw, tbl[i].mw, cpi, ill, last);
      check("tbl_cpi", 32'(cpi), 32'(tbl[i].cpi));
      check("tbl_illegal", 32'(ill), 32'(tbl[i].ill));
      check("tbl_last_state", 32'(last), 32'(tbl[i].last));
    end

    // Store abandoned by reset while waiting in MEM_WR.
    opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("mem_wr_wait", 32'({state, MemWrite}), 32'({4'd5, 1'b1}));
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 32'(dut_vec), 32'(exp_vec(15, 1'b0, 6'h2B, 6'h00)));
    @(posedge clk);
    #1;
    check("reset_held_edge", 32'(state), 32'd15);
    reset = 1'b1;
    @(negedge clk);
    check("rst_after_abort", 32'(dut_vec), 32'(exp_vec(15, 1'b0, 6'h2B, 6'h00)));
    @(posedge clk);
    #1;
    check("fetch_after_abort", 32'(state), 32'd0);

    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == 6'h15) op = 6'($urandom);
      fn = fns[$urandom_range(0, 5)];
      if (fn == 6'h07) fn = 6'($urandom);
      mw = $urandom_range(0, 3);
      run_instr(op, fn, $urandom_range(0, 2), mw, cpi, ill, last);
      check("rnd_cpi", 32'(cpi), 32'(exp_cpi(op, mw)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
